// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sharing one bank of SR state bits between NREQ requesters.
// Each accepted command takes two cycles: IDLE picks and captures a winner, APPLY updates q and acks.
module sr_bank_arbiter #(
   parameter int               NREQ    = 4,
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [2*NREQ-1:0]        req_op,
   input  logic [WIDTH*NREQ-1:0]    req_mask,
   output logic [NREQ-1:0]          req_ready,
   output logic [WIDTH-1:0]         q,
   output logic                     gnt_valid,
   output logic [$clog2(NREQ)-1:0]  gnt_id,
   output logic                     err,
   output logic [$clog2(NREQ)-1:0]  err_src,
   input  logic                     err_clr
);

   localparam int             IDW     = $clog2(NREQ);
   localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   typedef enum logic {IDLE, APPLY} state_t;

   state_t             state, state_nxt;
   logic [IDW-1:0]     ptr, ptr_nxt;
   logic [1:0]         op_r, op_nxt;
   logic [WIDTH-1:0]   mask_r, mask_nxt;
   logic [IDW-1:0]     gnt_id_nxt;
   logic               gnt_valid_nxt;
   logic [NREQ-1:0]    ready_nxt;
   logic [WIDTH-1:0]   q_nxt;
   logic               err_nxt;
   logic [IDW-1:0]     err_src_nxt;

   logic [1:0]         op_arr   [NREQ];
   logic [WIDTH-1:0]   mask_arr [NREQ];

   logic               found;
   logic [IDW-1:0]     winner;
   logic [IDW:0]       sum;
   logic [IDW-1:0]     cand;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign op_arr[gi]   = req_op[2*gi +: 2];
         assign mask_arr[gi] = req_mask[WIDTH*gi +: WIDTH];
      end
   endgenerate

   // Search from ptr upward, wrapping at NREQ (not at 2**IDW) so odd NREQ works.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      cand   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
         end
         cand = sum[IDW-1:0];
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      op_nxt        = op_r;
      mask_nxt      = mask_r;
      gnt_id_nxt    = gnt_id;
      gnt_valid_nxt = 1'b0;
      ready_nxt     = '0;
      q_nxt         = q;
      err_nxt       = err;
      err_src_nxt   = err_src;

      if (err_clr) begin
         err_nxt = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (found) begin
               op_nxt            = op_arr[winner];
               mask_nxt          = mask_arr[winner];
               gnt_id_nxt        = winner;
               gnt_valid_nxt     = 1'b1;
               ready_nxt[winner] = 1'b1;
               state_nxt         = APPLY;
            end
         end
         APPLY: begin
            // A new invalid command overrides a simultaneous err_clr.
            case (op_r)
               2'b10:   q_nxt = q | mask_r;
               2'b01:   q_nxt = q & ~mask_r;
               2'b11: begin
                  err_nxt     = 1'b1;
                  err_src_nxt = gnt_id;
               end
               default: ;
            endcase
            ptr_nxt   = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         op_r      <= '0;
         mask_r    <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         req_ready <= '0;
         q         <= RST_VAL;
         err       <= 1'b0;
         err_src   <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         op_r      <= op_nxt;
         mask_r    <= mask_nxt;
         gnt_id    <= gnt_id_nxt;
         gnt_valid <= gnt_valid_nxt;
         req_ready <= ready_nxt;
         q         <= q_nxt;
         err       <= err_nxt;
         err_src   <= err_src_nxt;
      end
   end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter: a reference model predicts each grant, a monitor checks it.
module tb_sr_bank_arbiter;

   localparam int         NREQ  = 4;
   localparam int         WIDTH = 8;
   localparam logic [7:0] RSTV  = 8'hA5;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid;
   logic [2*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_mask;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      q;
   logic                  gnt_valid;
   logic [1:0]            gnt_id;
   logic                  err;
   logic [1:0]            err_src;
   logic                  err_clr = 1'b0;

   sr_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RST_VAL(RSTV)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_mask(req_mask),
      .req_ready(req_ready), .q(q), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
      .err(err), .err_src(err_src), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { int id; logic [7:0] q; logic err; int src; } exp_t;
   exp_t sb[$];

   logic       pend   [NREQ];
   logic [1:0] c_op   [NREQ];
   logic [7:0] c_mask [NREQ];
   logic [NREQ-1:0] rdy_lat = '0;
   bit hold_all  = 1'b0;
   bit rand_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void drive_ports();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = pend[i];
         req_op[2*i +: 2]     = c_op[i];
         req_mask[8*i +: 8]   = c_mask[i];
      end
   endfunction

   function automatic bit any_pend();
      bit a = 1'b0;
      for (int i = 0; i < NREQ; i++) a |= pend[i];
      return a;
   endfunction

   task automatic post(input int i, input logic [1:0] o, input logic [7:0] m);
      pend[i] = 1'b1; c_op[i] = o; c_mask[i] = m;
      drive_ports();
   endtask

   // One cycle of requester behaviour: a ready seen in APPLY is an ack at the following edge
   // unless reset intervened.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (rdy_lat[i] && rst_n) begin
            if (hold_all) begin
               c_op[i] = 2'b00; c_mask[i] = 8'($urandom);
            end else begin
               pend[i] = 1'b0;
            end
         end
      end
      rdy_lat = req_ready;
      if (rand_mode) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1; c_op[i] = 2'($urandom_range(3)); c_mask[i] = 8'($urandom);
            end
         end
         err_clr = ($urandom_range(7) == 0);
      end
      drive_ports();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (any_pend() && n < 100) begin tick(); n++; end
      check({name, "_drain"}, 32'(any_pend()), 0);
      tick();
   endtask

   task automatic wait_ready(input int i, input string name);
      int n = 0;
      do begin tick(); n++; end while (!req_ready[i] && n < 50);
      check({name, "_ready"}, 32'(req_ready[i]), 1);
   endtask

   // Reference model: round-robin from a pointer, plain per-bit SR semantics.
   initial begin : model
      logic [7:0] mq;
      int         mptr, mid, msrc, idx;
      bit         mapply, hit;
      logic [1:0] mop;
      logic [7:0] mmask;
      logic       merr;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq = RSTV; mptr = 0; mapply = 1'b0; merr = 1'b0; msrc = 0; sb.delete();
         end else if (mapply) begin
            if (mop == 2'b11) begin
               merr = 1'b1; msrc = mid;
            end else begin
               if (err_clr) merr = 1'b0;
               for (int b = 0; b < 8; b++) begin
                  if (mmask[b]) begin
                     if (mop == 2'b10) mq[b] = 1'b1;
                     else if (mop == 2'b01) mq[b] = 1'b0;
                  end
               end
            end
            sb.push_back('{mid, mq, merr, msrc});
            mptr = (mid + 1) % NREQ;
            mapply = 1'b0;
         end else begin
            if (err_clr) merr = 1'b0;
            hit = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
               idx = (mptr + k) % NREQ;
               if (!hit && req_valid[idx]) begin
                  hit = 1'b1; mid = idx;
                  mop = req_op[2*idx +: 2]; mmask = req_mask[8*idx +: 8];
               end
            end
            mapply = hit;
         end
      end
   end

   initial begin : monitor
      logic [1:0] g;
      logic [3:0] r;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (gnt_valid) begin
               g = gnt_id; r = req_ready;
               @(posedge clk); #1;
               if (rst_n) begin
                  check("sb_nonempty", 32'(sb.size() != 0), 1);
                  if (sb.size() != 0) begin
                     e = sb.pop_front();
                     check("gnt_id", 32'(g), e.id);
                     check("ack_onehot", 32'(r), 32'(1) << e.id);
                     check("q", 32'(q), 32'(e.q));
                     check("err", 32'(err), 32'(e.err));
                     check("err_src", 32'(err_src), e.src);
                  end
               end
            end else begin
               check("ready_idle", 32'(req_ready), 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin : stim
      int order [5];
      int when  [5];
      int ng, t, n, exp_id;
      for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; c_op[i] = '0; c_mask[i] = '0; end
      drive_ports();
      repeat (3) @(negedge clk);

      // reset values
      check("rst_q", 32'(q), 32'h A5);
      check("rst_err", 32'(err), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_gnt_valid", 32'(gnt_valid), 0);
      check("rst_gnt_id", 32'(gnt_id), 0);
      check("rst_err_src", 32'(err_src), 0);
      rst_n = 1'b1;

      // all four held continuously from ptr=0
      hold_all = 1'b1;
      for (int i = 0; i < NREQ; i++) post(i, 2'b00, 8'h00);
      ng = 0; t = 0;
      while (ng < 5 && t < 40) begin
         tick(); t++;
         if (gnt_valid) begin order[ng] = gnt_id; when[ng] = t; ng++; end
      end
      hold_all = 1'b0;
      check("rr_count", ng, 5);
      for (int i = 0; i < 5; i++) check("rr_order", order[i], i % NREQ);
      for (int i = 1; i < 5; i++) check("rr_spacing", when[i] - when[i-1], 2);
      wait_idle("rr");

      // set low nibble from zero; ack lasts exactly one cycle
      post(0, 2'b01, 8'hFF);
      wait_idle("clr_all");
      check("clr_all_q", 32'(q), 32'h00);
      post(0, 2'b10, 8'h0F);
      wait_ready(0, "set");
      check("set_ack", 32'(req_ready), 32'b0001);
      check("set_gnt_valid", 32'(gnt_valid), 1);
      tick();
      check("set_ack_once", 32'(req_ready), 0);
      check("set_q", 32'(q), 32'h0F);

      // reset masked bits, then hold op still acked
      post(3, 2'b10, 8'hFF);
      wait_idle("fill");
      check("fill_q", 32'(q), 32'hFF);
      post(3, 2'b01, 8'hF0);
      wait_idle("reset_hi");
      check("reset_hi_q", 32'(q), 32'h0F);
      post(3, 2'b00, 8'hF0);
      wait_ready(3, "hold");
      check("hold_ack", 32'(req_ready), 32'b1000);
      wait_idle("hold");
      check("hold_q", 32'(q), 32'h0F);

      // invalid command, then invalid with mask 0 racing err_clr
      post(2, 2'b11, 8'hFF);
      wait_idle("inv");
      check("inv_q", 32'(q), 32'h0F);
      check("inv_err", 32'(err), 1);
      check("inv_err_src", 32'(err_src), 2);
      post(1, 2'b11, 8'h00);
      wait_ready(1, "inv2");
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("inv2_err", 32'(err), 1);
      check("inv2_err_src", 32'(err_src), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("errclr_err", 32'(err), 0);
      check("errclr_err_src", 32'(err_src), 1);

      // reset while req1 is in APPLY
      post(1, 2'b10, 8'hFF);
      post(3, 2'b00, 8'h00);
      n = 0;
      do begin tick(); n++; end while (!(gnt_valid && gnt_id == 2'd1) && n < 20);
      check("mid_apply_seen", 32'(gnt_valid && gnt_id == 2'd1), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_q", 32'(q), 32'h A5);
      check("mid_rst_ready", 32'(req_ready), 0);
      check("mid_rst_gnt_valid", 32'(gnt_valid), 0);
      check("mid_rst_err", 32'(err), 0);
      tick();
      tick();
      rst_n = 1'b1;
      check("mid_rst_req1_pending", 32'(pend[1]), 1);
      exp_id = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (pend[i]) exp_id = i;
      n = 0;
      do begin tick(); n++; end while (!gnt_valid && n < 20);
      check("post_rst_gnt", 32'(gnt_id), exp_id);
      wait_idle("post_rst");

      // randomized traffic against the model
      rand_mode = 1'b1;
      repeat (400) tick();
      rand_mode = 1'b0;
      err_clr = 1'b0;
      wait_idle("random");
      tick();
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
